// File: rtl/serial_mirror.sv
// Multi-cycle bit-reversal coprocessor: reverses the low LEN bits of an operand,
// one bit per clock, behind valid/ready handshakes on both sides.
module serial_mirror #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LENW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LENW-1:0]  in_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] dst;
  logic [LENW-1:0]  cnt;
  logic [LENW-1:0]  eff_len_c;
  logic             in_ready_nxt;
  logic             out_valid_nxt;
  logic             busy_nxt;

  // Zero and oversize lengths both mean a full-width reversal.
  always_comb begin
    eff_len_c = in_len;
    if (in_len == '0 || in_len > LENW'(WIDTH)) begin
      eff_len_c = LENW'(WIDTH);
    end
  end

  // State and registered handshake/status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (cnt == LENW'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are decoded from the next state so they line up with the state register.
  always_comb begin
    in_ready_nxt  = 1'b0;
    out_valid_nxt = 1'b0;
    busy_nxt      = 1'b1;
    case (state_nxt)
      IDLE: begin
        in_ready_nxt = 1'b1;
        busy_nxt     = 1'b0;
      end
      DONE:    out_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  // Operand is captured at accept; LSB of src walks into the bottom of dst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src <= '0;
      dst <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src <= in_data;
            dst <= '0;
            cnt <= eff_len_c;
          end
        end
        SHIFT: begin
          dst <= {dst[WIDTH-2:0], src[0]};
          src <= src >> 1;
          cnt <= cnt - LENW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = dst;

endmodule

// File: tb/tb_serial_mirror.sv
// Directed and randomized checks for serial_mirror: latency, result bits,
// backpressure, mid-operation reset and one-result-per-accept.
module tb_serial_mirror;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [4:0]  in_len;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;

  serial_mirror #(.WIDTH(16), .LENW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_len    (in_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Handshake monitor: every accepted operand must yield exactly one taken result.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    if (rst_n && out_valid && out_ready) done_cnt <= done_cnt + 1;
  end

  function automatic int eff_len(input logic [4:0] l);
    return (l == 5'd0 || l > 5'd16) ? 16 : int'(l);
  endfunction

  function automatic logic [15:0] ref_rev(input logic [15:0] d, input logic [4:0] l);
    int n;
    logic [15:0] r;
    n = eff_len(l);
    r = '0;
    for (int i = 0; i < n; i++) r[i] = d[n-1-i];
    return r;
  endfunction

  // Issues one operand and waits (bounded) for out_valid; scrambles inputs while busy.
  task automatic run_op(input logic [15:0] d, input logic [4:0] l,
                        output logic [15:0] res, output int lat, output int busy_n);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    @(posedge clk); #1;
    lat    = 0;
    busy_n = 0;
    in_data  = 16'($urandom);
    in_len   = 5'($urandom);
    in_valid = 1'($urandom);
    while (!out_valid && lat < 40) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
      in_data  = 16'($urandom);
      in_len   = 5'($urandom);
      in_valid = 1'($urandom);
    end
    if (busy) busy_n++;
    in_valid = 1'b0;
    res = out_data;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'hABCD;
    in_len   = 5'd4;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_idle: busy=%b in_ready=%b expected 0/1", busy, in_ready); end
  endtask

  task automatic test_full_width;
    logic [15:0] res;
    int lat, bn;
    out_ready = 1'b1;
    run_op(16'h0001, 5'd16, res, lat, bn);
    checks++; if (res !== 16'h8000) begin failures++; $display("FAIL full_result: got %h expected 8000", res); end
    checks++; if (lat !== 16) begin failures++; $display("FAIL full_latency: got %0d expected 16", lat); end
    checks++; if (bn !== 17) begin failures++; $display("FAIL full_busy_cycles: got %0d expected 17", bn); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL full_return_idle: out_valid=%b busy=%b in_ready=%b expected 0/0/1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_patterns;
    logic [15:0] vd [5] = '{16'h00B1, 16'hFFB1, 16'h1234, 16'h1234, 16'hFFFF};
    logic [4:0]  vl [5] = '{5'd8, 5'd8, 5'd0, 5'd31, 5'd1};
    logic [15:0] ve [5] = '{16'h008D, 16'h008D, 16'h2C48, 16'h2C48, 16'h0001};
    int          vt [5] = '{8, 8, 16, 16, 1};
    logic [15:0] res;
    int lat, bn;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_op(vd[i], vl[i], res, lat, bn);
      checks++; if (res !== ve[i]) begin failures++; $display("FAIL pattern%0d_result: got %h expected %h", i, res, ve[i]); end
      checks++; if (lat !== vt[i]) begin failures++; $display("FAIL pattern%0d_latency: got %0d expected %0d", i, lat, vt[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] res;
    int lat, bn;
    out_ready = 1'b0;
    run_op(16'hFFFF, 5'd4, res, lat, bn);
    checks++; if (res !== 16'h000F || lat !== 4) begin failures++; $display("FAIL bp_result: got %h lat %0d expected 000F lat 4", res, lat); end
    // A competing operand during the stall must be ignored.
    in_valid = 1'b1;
    in_data  = 16'h00B1;
    in_len   = 5'd8;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 16'h000F || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d: out_valid=%b out_data=%h in_ready=%b expected 1/000F/0", c, out_valid, out_data, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    run_op(16'h00B1, 5'd8, res, lat, bn);
    checks++; if (res !== 16'h008D || lat !== 8) begin failures++; $display("FAIL bp_second_op: got %h lat %0d expected 008D lat 8", res, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int guard;
    int spurious;
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_len   = 5'd16;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1 || out_data !== 16'h0003) begin failures++; $display("FAIL midrst_pre: busy=%b out_data=%h expected 1/0003", busy, out_data); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000 || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_state: in_ready=%b out_valid=%b out_data=%h busy=%b expected 1/0/0000/0", in_ready, out_valid, out_data, busy);
    end
    rst_n = 1'b1;
    spurious = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checks++; if (spurious !== 0) begin failures++; $display("FAIL midrst_spurious: got %0d active cycles expected 0", spurious); end
  endtask

  task automatic test_random;
    logic [15:0] d, res, exp;
    logic [4:0]  l;
    int lat, bn, stall, acc0, done0;
    acc0  = acc_cnt;
    done0 = done_cnt;
    for (int n = 0; n < 1000; n++) begin
      d = 16'($urandom);
      l = 5'($urandom);
      exp = ref_rev(d, l);
      out_ready = 1'b0;
      run_op(d, l, res, lat, bn);
      checks++; if (res !== exp) begin failures++; $display("FAIL rand%0d_result: d=%h l=%0d got %h expected %h", n, d, l, res, exp); end
      checks++; if (lat !== eff_len(l)) begin failures++; $display("FAIL rand%0d_latency: got %0d expected %0d", n, lat, eff_len(l)); end
      stall = $urandom_range(0, 3);
      repeat (stall) @(posedge clk);
      #0;
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin failures++; $display("FAIL rand%0d_stall: out_valid=%b out_data=%h expected 1/%h", n, out_valid, out_data, exp); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rand%0d_handoff: out_valid=%b in_ready=%b expected 0/1", n, out_valid, in_ready); end
    end
    @(posedge clk); #1;
    checks++; if (acc_cnt - acc0 !== 1000) begin failures++; $display("FAIL rand_accepts: got %0d expected 1000", acc_cnt - acc0); end
    checks++; if (done_cnt - done0 !== 1000) begin failures++; $display("FAIL rand_results: got %0d expected 1000", done_cnt - done0); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    out_ready = 1'b1;
    test_reset();
    test_full_width();
    test_patterns();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
